// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction bus, decode handshake and redirect signals of the fetch stage
// dataF layout: [96] valid, [95:64] raw_instr, [63:0] pc.
interface fetch_stage_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic [96:0] dataF;
  logic        out_ready;
  logic        flush;
  logic [63:0] redirect_pc;

  modport master (
    output ireq_valid, ireq_addr, dataF,
    input  iresp_data_ok, iresp_data, out_ready, flush, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, dataF,
    output iresp_data_ok, iresp_data, out_ready, flush, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV64 instruction fetch: PC, word requests, two-entry buffer, flush/redirect
// Optional: FETCH_MISALIGN_CHECK_EN emits a zero-word record for a misaligned redirect and stalls.
module fetch_stage #(
  parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_disc_addr;
  fetch_data_t r_out;
  logic        r_pend_valid;
  logic [31:0] r_pend_instr;
  logic [63:0] r_pend_pc;
  logic        r_stall;

  logic [63:0] w_redirect;
  logic        w_misalign;
  logic [63:0] w_pc_inc;
  logic        w_room;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_redirect = bus.redirect_pc;
  assign w_misalign = |bus.redirect_pc[1:0];
`else
  assign w_redirect = {bus.redirect_pc[63:2], 2'b00};
  assign w_misalign = 1'b0;
`endif

  assign w_pc_inc = r_pc + 64'd4;
  assign w_room   = !r_out.valid || bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= PCINIT;
      r_disc_addr  <= '0;
      r_out        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_instr <= '0;
      r_pend_pc    <= '0;
      r_stall      <= 1'b0;
    end else if (bus.flush) begin
      r_pc         <= w_redirect;
      r_pend_valid <= 1'b0;
      r_stall      <= w_misalign;
      if (w_misalign) begin
        r_out   <= '{valid: 1'b1, raw_instr: 32'h0000_0000, pc: w_redirect};
        r_state <= S_HOLD;
      end else begin
        r_out.valid <= 1'b0;
        case (r_state)
          S_FETCH: begin
            // An unanswered request must still be completed on the bus before refetching.
            if (!bus.iresp_data_ok) begin
              r_state     <= S_DISCARD;
              r_disc_addr <= r_pc;
            end
          end
          S_HOLD:    r_state <= S_FETCH;
          S_DISCARD: r_state <= S_DISCARD;
          default:   r_state <= S_FETCH;
        endcase
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.iresp_data_ok) begin
            r_pc <= w_pc_inc;
            if (w_room) begin
              r_out <= '{valid: 1'b1, raw_instr: bus.iresp_data, pc: r_pc};
            end else begin
              r_pend_valid <= 1'b1;
              r_pend_instr <= bus.iresp_data;
              r_pend_pc    <= r_pc;
              r_state      <= S_HOLD;
            end
          end else if (r_out.valid && bus.out_ready) begin
            r_out.valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            if (r_pend_valid && !r_stall) begin
              r_out        <= '{valid: 1'b1, raw_instr: r_pend_instr, pc: r_pend_pc};
              r_pend_valid <= 1'b0;
              r_state      <= S_FETCH;
            end else begin
              r_out.valid <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (bus.iresp_data_ok) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.ireq_valid = !reset && (r_state != S_HOLD);
  assign bus.ireq_addr  = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
  assign bus.dataF      = r_out;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage: reset, backpressure, flush, wrap, misaligned redirect
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];
  logic [95:0] mon_e;

  fetch_stage_if bus();

  fetch_stage #(.PCINIT(64'h0000_0000_8000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory answers every request in the same cycle whenever mem_en is high.
  assign bus.iresp_data_ok = mem_en && bus.ireq_valid;
  assign bus.iresp_data    = mem_word(bus.ireq_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_q.push_back({mem_word(pc), pc});
  endtask

  always @(negedge clk) begin
    if (!reset && bus.dataF[96] && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record actual pc=%h required none", bus.dataF[63:0]);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_pc", bus.dataF[63:0], mon_e[63:0]);
        check("rec_instr", {32'h0, bus.dataF[95:64]}, {32'h0, mon_e[95:64]});
      end
    end
  end

  initial begin
    bus.out_ready   = 1'b1;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) tick();
    check("rst_ireq_valid", {63'h0, bus.ireq_valid}, 64'h0);
    check("rst_dataF_valid", {63'h0, bus.dataF[96]}, 64'h0);
    check("rst_dataF_pc", bus.dataF[63:0], 64'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ireq_valid", {63'h0, bus.ireq_valid}, 64'h1);
    check("post_rst_addr", bus.ireq_addr, 64'h8000_0000);

    // Streaming at one instruction per cycle.
    mem_en = 1'b1;
    push_exp(64'h8000_0000);
    push_exp(64'h8000_0004);
    push_exp(64'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", bus.ireq_addr, 64'h8000_0000 + 64'(4 * i));
      if (i > 0) check("seq_dataF_pc", bus.dataF[63:0], 64'h8000_0000 + 64'(4 * (i - 1)));
      tick();
    end
    mem_en = 1'b0;
    repeat (2) tick();
    check("drain_valid", {63'h0, bus.dataF[96]}, 64'h0);
    check("drain_addr", bus.ireq_addr, 64'h8000_000C);

    // Backpressure: two words buffered, bus idle in HOLD.
    bus.out_ready = 1'b0;
    mem_en = 1'b1;
    push_exp(64'h8000_000C);
    push_exp(64'h8000_0010);
    tick();
    tick();
    mem_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_ireq_valid", {63'h0, bus.ireq_valid}, 64'h0);
      check("hold_dataF_valid", {63'h0, bus.dataF[96]}, 64'h1);
      check("hold_dataF_pc", bus.dataF[63:0], 64'h8000_000C);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("bp_drained", 64'(exp_q.size()), 64'h0);
    check("bp_next_addr", bus.ireq_addr, 64'h8000_0014);

    // Flush with a request outstanding; second flush while discarding.
    bus.flush = 1'b1;
    bus.redirect_pc = 64'h8000_0080;
    tick();
    check("disc_addr_0", bus.ireq_addr, 64'h8000_0014);
    bus.redirect_pc = 64'h8000_0100;
    tick();
    bus.flush = 1'b0;
    check("disc_ireq_valid", {63'h0, bus.ireq_valid}, 64'h1);
    check("disc_addr_1", bus.ireq_addr, 64'h8000_0014);
    tick();
    check("disc_addr_2", bus.ireq_addr, 64'h8000_0014);
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
    check("post_disc_addr", bus.ireq_addr, 64'h8000_0100);
    check("post_disc_valid", {63'h0, bus.dataF[96]}, 64'h0);
    push_exp(64'h8000_0100);
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
    tick();

    // Flush coincident with data_ok: that word is dropped.
    mem_en = 1'b1;
    bus.flush = 1'b1;
    bus.redirect_pc = 64'h8000_0200;
    tick();
    bus.flush = 1'b0;
    check("coinc_addr", bus.ireq_addr, 64'h8000_0200);
    check("coinc_no_record", {63'h0, bus.dataF[96]}, 64'h0);
    push_exp(64'h8000_0200);
    tick();
    mem_en = 1'b0;
    check("coinc_dataF_pc", bus.dataF[63:0], 64'h8000_0200);
    tick();

    // PC wrap at the top of the address space.
    mem_en = 1'b1;
    bus.flush = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    bus.flush = 1'b0;
    check("wrap_addr_top", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_addr_zero", bus.ireq_addr, 64'h0);
    push_exp(64'h0);
    tick();
    mem_en = 1'b0;
    repeat (2) tick();

    // Misaligned redirect.
    mem_en = 1'b1;
    bus.flush = 1'b1;
    bus.redirect_pc = 64'h8000_0102;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_q.push_back({32'h0000_0000, 64'h8000_0102});
    tick();
    bus.flush = 1'b0;
    mem_en = 1'b0;
    check("misalign_no_req", {63'h0, bus.ireq_valid}, 64'h0);
    tick();
    tick();
    check("misalign_stall", {63'h0, bus.ireq_valid}, 64'h0);
    check("misalign_one_record", {63'h0, bus.dataF[96]}, 64'h0);
`else
    tick();
    bus.flush = 1'b0;
    check("misalign_addr", bus.ireq_addr, 64'h8000_0100);
    push_exp(64'h8000_0100);
    tick();
    mem_en = 1'b0;
    tick();
`endif

    repeat (2) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
